// File: rtl/user_timer.sv
// OBI subordinate timer: prescaled 32-bit up-counter with compare match,
// optional auto-reload and a level interrupt for the user domain.

package user_timer_pkg;
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam int unsigned SbrIdWidth = 4;
    localparam obi_cfg_t SbrObiCfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: SbrIdWidth};

    typedef struct packed {
        logic [31:0]           addr;
        logic                  we;
        logic [3:0]            be;
        logic [31:0]           wdata;
        logic [SbrIdWidth-1:0] aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        sbr_obi_a_chan_t a;
        logic            req;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0]           rdata;
        logic [SbrIdWidth-1:0] rid;
        logic                  err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sbr_obi_r_chan_t r;
    } sbr_obi_rsp_t;
endpackage

module user_timer
    import user_timer_pkg::*;
#(
    parameter obi_cfg_t ObiCfg    = SbrObiCfg,
    parameter type      obi_req_t = sbr_obi_req_t,
    parameter type      obi_rsp_t = sbr_obi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    output logic     irq_o
);

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    logic                      en_q, auto_reload_q, irq_en_q, match_q;
    logic [7:0]                prescale_q, presc_cnt_q;
    logic [31:0]               count_q, compare_q, count_ticked, rdata_d;
    logic                      rvalid_q, err_q;
    logic [31:0]               rdata_q;
    logic [ObiCfg.IdWidth-1:0] rid_q;

    logic        req, we, hit, wr, tick, cmp_eq;
    logic [11:0] offset;
    logic [3:0]  be;
    logic [31:0] wdata;
    reg_sel_e    sel;
    logic        unused_addr_hi;

    assign req            = obi_req_i.req;
    assign we             = obi_req_i.a.we;
    assign be             = obi_req_i.a.be;
    assign wdata          = obi_req_i.a.wdata;
    assign offset         = obi_req_i.a.addr[11:0];
    assign unused_addr_hi = ^obi_req_i.a.addr[31:12];
    assign hit            = (offset[11:4] == '0) && (offset[1:0] == 2'b00);
    assign sel            = reg_sel_e'(offset[3:2]);
    assign wr             = req && we && hit;

    assign tick   = en_q && (presc_cnt_q == prescale_q);
    assign cmp_eq = (count_q == compare_q);

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  byte_en);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (byte_en[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    always_comb begin
        count_ticked = count_q;
        if (tick) count_ticked = (cmp_eq && auto_reload_q) ? '0 : count_q + 32'd1;
    end

    always_comb begin
        rdata_d = '0;
        unique case (sel)
            REG_CTRL:    rdata_d = {16'h0000, prescale_q, 5'b00000, irq_en_q, auto_reload_q, en_q};
            REG_COUNT:   rdata_d = count_q;
            REG_COMPARE: rdata_d = compare_q;
            REG_STATUS:  rdata_d = {31'h0, match_q};
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q          <= 1'b0;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            prescale_q    <= '0;
            presc_cnt_q   <= '0;
            count_q       <= '0;
            compare_q     <= '0;
            match_q       <= 1'b0;
            rvalid_q      <= 1'b0;
            rid_q         <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            if (!en_q || tick) presc_cnt_q <= '0;
            else               presc_cnt_q <= presc_cnt_q + 8'd1;

            // Bus write merges over the tick-updated value so written bytes win.
            if (wr && sel == REG_COUNT) count_q <= merge_be(count_ticked, wdata, be);
            else                        count_q <= count_ticked;

            if (wr && sel == REG_COMPARE) compare_q <= merge_be(compare_q, wdata, be);

            if (wr && sel == REG_CTRL) begin
                if (be[0]) {irq_en_q, auto_reload_q, en_q} <= wdata[2:0];
                if (be[1]) prescale_q <= wdata[15:8];
            end

            if (tick && cmp_eq)                                      match_q <= 1'b1;
            else if (wr && sel == REG_STATUS && be[0] && wdata[0])   match_q <= 1'b0;

            rvalid_q <= req;
            if (req) begin
                rid_q   <= obi_req_i.a.aid;
                err_q   <= !hit;
                rdata_q <= (we || !hit) ? '0 : rdata_d;
            end
        end
    end

    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = req;
        obi_rsp_o.rvalid  = rvalid_q;
        obi_rsp_o.r.rdata = rdata_q;
        obi_rsp_o.r.rid   = rid_q;
        obi_rsp_o.r.err   = err_q;
    end

    assign irq_o = match_q & irq_en_q;

endmodule
